// File: rtl/cpu_bus_arbiter.sv
// Arbitrates the single external req/ack memory bus between the fetch port and the MEM-stage data port.
// Raises stall requests while a port waits, holds returned data while stalled, and aborts on flush or timeout.
module cpu_bus_arbiter #(
  parameter int IF_STALL_BIT  = 1,
  parameter int MEM_STALL_BIT = 4,
  parameter int TIMEOUT       = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stallreq,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stallreq,
  output logic        bus_cyc,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_HOLD = 3'd3,
    D_HOLD = 3'd4
  } state_t;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);
  localparam logic [2:0] IF_BIT   = 3'(IF_STALL_BIT);
  localparam logic [2:0] MEM_BIT  = 3'(MEM_STALL_BIT);

  state_t      state_r, state_next_s;
  logic [9:0]  cnt_r, cnt_next_s;
  logic [31:0] if_hold_r, if_hold_next_s;
  logic [31:0] mem_hold_r, mem_hold_next_s;
  logic        bus_cyc_r, bus_cyc_next_s;
  logic        bus_we_r, bus_we_next_s;
  logic [3:0]  bus_sel_r, bus_sel_next_s;
  logic [31:0] bus_addr_r, bus_addr_next_s;
  logic [31:0] bus_wdata_r, bus_wdata_next_s;
  logic        busy_s, ack_s, timeout_s;

  assign busy_s    = (state_r == I_BUSY) || (state_r == D_BUSY);
  // Flush outranks both ack and timeout, so neither is seen in a flush cycle.
  assign ack_s     = busy_s & bus_ack & ~flush;
  assign timeout_s = busy_s & ~bus_ack & ~flush & (cnt_r == CNT_LAST);

  // Next-state and next-value logic for the FSM, bus launch registers, counter and hold registers.
  always_comb begin
    state_next_s     = state_r;
    cnt_next_s       = cnt_r;
    if_hold_next_s   = if_hold_r;
    mem_hold_next_s  = mem_hold_r;
    bus_cyc_next_s   = bus_cyc_r;
    bus_we_next_s    = bus_we_r;
    bus_sel_next_s   = bus_sel_r;
    bus_addr_next_s  = bus_addr_r;
    bus_wdata_next_s = bus_wdata_r;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_next_s = IDLE;
        end else if (mem_req) begin
          state_next_s     = D_BUSY;
          cnt_next_s       = 10'd0;
          bus_cyc_next_s   = 1'b1;
          bus_we_next_s    = mem_we;
          bus_sel_next_s   = mem_sel;
          bus_addr_next_s  = mem_addr;
          bus_wdata_next_s = mem_wdata;
        end else if (if_req) begin
          state_next_s     = I_BUSY;
          cnt_next_s       = 10'd0;
          bus_cyc_next_s   = 1'b1;
          bus_we_next_s    = 1'b0;
          bus_sel_next_s   = 4'hF;
          bus_addr_next_s  = if_addr;
          bus_wdata_next_s = 32'd0;
        end else begin
          state_next_s = IDLE;
        end
      end
      I_BUSY, D_BUSY: begin
        if (flush) begin
          state_next_s   = IDLE;
          bus_cyc_next_s = 1'b0;
          cnt_next_s     = 10'd0;
        end else if (bus_ack) begin
          bus_cyc_next_s = 1'b0;
          cnt_next_s     = 10'd0;
          if (state_r == D_BUSY) begin
            mem_hold_next_s = bus_rdata;
            state_next_s    = stall[MEM_BIT] ? D_HOLD : IDLE;
          end else begin
            if_hold_next_s = bus_rdata;
            state_next_s   = stall[IF_BIT] ? I_HOLD : IDLE;
          end
        end else if (cnt_r == CNT_LAST) begin
          state_next_s   = IDLE;
          bus_cyc_next_s = 1'b0;
          cnt_next_s     = 10'd0;
        end else begin
          cnt_next_s = cnt_r + 10'd1;
        end
      end
      I_HOLD: begin
        if (flush || !stall[IF_BIT]) state_next_s = IDLE;
        else                         state_next_s = I_HOLD;
      end
      D_HOLD: begin
        if (flush || !stall[MEM_BIT]) state_next_s = IDLE;
        else                          state_next_s = D_HOLD;
      end
      default: begin
        state_next_s   = IDLE;
        bus_cyc_next_s = 1'b0;
        cnt_next_s     = 10'd0;
      end
    endcase
  end

  // State, counter, hold and bus-output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= 10'd0;
      if_hold_r   <= 32'd0;
      mem_hold_r  <= 32'd0;
      bus_cyc_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_sel_r   <= 4'd0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      if_hold_r   <= if_hold_next_s;
      mem_hold_r  <= mem_hold_next_s;
      bus_cyc_r   <= bus_cyc_next_s;
      bus_we_r    <= bus_we_next_s;
      bus_sel_r   <= bus_sel_next_s;
      bus_addr_r  <= bus_addr_next_s;
      bus_wdata_r <= bus_wdata_next_s;
    end
  end

  // Port read data: live bus data on the ack cycle, held data while stalled, zero otherwise.
  always_comb begin
    if_rdata  = 32'd0;
    mem_rdata = 32'd0;
    if ((state_r == I_BUSY) && ack_s) if_rdata = bus_rdata;
    else if (state_r == I_HOLD)       if_rdata = if_hold_r;
    else                              if_rdata = 32'd0;
    if ((state_r == D_BUSY) && ack_s) mem_rdata = bus_rdata;
    else if (state_r == D_HOLD)       mem_rdata = mem_hold_r;
    else                              mem_rdata = 32'd0;
  end

  assign if_stallreq  = if_req & ~flush & ~((state_r == I_BUSY) & (bus_ack | timeout_s))
                        & ~(state_r == I_HOLD);
  assign mem_stallreq = mem_req & ~flush & ~((state_r == D_BUSY) & (bus_ack | timeout_s))
                        & ~(state_r == D_HOLD);

  assign bus_cyc     = bus_cyc_r;
  assign bus_we      = bus_we_r;
  assign bus_sel     = bus_sel_r;
  assign bus_addr    = bus_addr_r;
  assign bus_wdata   = bus_wdata_r;
  assign bus_timeout = timeout_s;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scenario-driven bench for cpu_bus_arbiter: expected read data is queued when the bus ack is driven
// and popped when the port presents it; control/bus outputs are compared inline.
module tb_cpu_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  stall;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stallreq;
  logic        mem_req, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_stallreq;
  logic        bus_cyc, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, bus_timeout;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  cpu_bus_arbiter dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stallreq(if_stallreq),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stallreq(mem_stallreq),
    .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_timeout(bus_timeout)
  );

  task automatic drive_idle();
    stall = 6'd0; flush = 1'b0; if_req = 1'b0; if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    bus_rdata = 32'd0; bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    #2;
    n_cmp++; if (bus_cyc !== 1'b0) begin n_err++; $display("FAIL reset_cyc: got %b want 0", bus_cyc); end
    n_cmp++; if (bus_addr !== 32'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus_addr); end
    n_cmp++; if (bus_sel !== 4'd0) begin n_err++; $display("FAIL reset_sel: got %h want 0", bus_sel); end
    n_cmp++; if (bus_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", bus_timeout); end
    reset_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h100; #2;
    n_cmp++; if (if_stallreq !== 1'b1) begin n_err++; $display("FAIL fetch_stall_idle: got %b want 1", if_stallreq); end
    @(negedge clk); #2;
    n_cmp++; if (bus_cyc !== 1'b1) begin n_err++; $display("FAIL fetch_cyc: got %b want 1", bus_cyc); end
    n_cmp++; if (bus_addr !== 32'h100) begin n_err++; $display("FAIL fetch_addr: got %h want 100", bus_addr); end
    n_cmp++; if (bus_sel !== 4'hF) begin n_err++; $display("FAIL fetch_sel: got %h want f", bus_sel); end
    n_cmp++; if (if_stallreq !== 1'b1) begin n_err++; $display("FAIL fetch_stall_wait: got %b want 1", if_stallreq); end
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h3C010001; if_q.push_back(32'h3C010001); #2;
    exp_v = if_q.pop_front();
    n_cmp++; if (if_rdata !== exp_v) begin n_err++; $display("FAIL fetch_rdata: got %h want %h", if_rdata, exp_v); end
    n_cmp++; if (if_stallreq !== 1'b0) begin n_err++; $display("FAIL fetch_stall_ack: got %b want 0", if_stallreq); end
    @(negedge clk); drive_idle(); #2;
    n_cmp++; if (bus_cyc !== 1'b0) begin n_err++; $display("FAIL fetch_cyc_drop: got %b want 0", bus_cyc); end
  endtask

  task automatic test_contention();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
    @(negedge clk); #2;
    n_cmp++; if (bus_we !== 1'b1) begin n_err++; $display("FAIL cont_we: got %b want 1", bus_we); end
    n_cmp++; if (bus_addr !== 32'h200) begin n_err++; $display("FAIL cont_addr: got %h want 200", bus_addr); end
    n_cmp++; if (bus_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL cont_wdata: got %h want deadbeef", bus_wdata); end
    n_cmp++; if (bus_sel !== 4'b0011) begin n_err++; $display("FAIL cont_sel: got %h want 3", bus_sel); end
    n_cmp++; if (if_stallreq !== 1'b1) begin n_err++; $display("FAIL cont_if_stall: got %b want 1", if_stallreq); end
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h11111111; mem_q.push_back(32'h11111111); #2;
    exp_v = mem_q.pop_front();
    n_cmp++; if (mem_rdata !== exp_v) begin n_err++; $display("FAIL cont_mem_rdata: got %h want %h", mem_rdata, exp_v); end
    n_cmp++; if (mem_stallreq !== 1'b0) begin n_err++; $display("FAIL cont_mem_stall: got %b want 0", mem_stallreq); end
    n_cmp++; if (if_stallreq !== 1'b1) begin n_err++; $display("FAIL cont_if_stall_ack: got %b want 1", if_stallreq); end
    @(negedge clk); bus_ack = 1'b0; mem_req = 1'b0; mem_we = 1'b0; #2;
    n_cmp++; if (bus_cyc !== 1'b0) begin n_err++; $display("FAIL cont_gap_cyc: got %b want 0", bus_cyc); end
    @(negedge clk); #2;
    n_cmp++; if (bus_addr !== 32'h300) begin n_err++; $display("FAIL cont_fetch_addr: got %h want 300", bus_addr); end
    n_cmp++; if (bus_we !== 1'b0) begin n_err++; $display("FAIL cont_fetch_we: got %b want 0", bus_we); end
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h24020005; if_q.push_back(32'h24020005); #2;
    exp_v = if_q.pop_front();
    n_cmp++; if (if_rdata !== exp_v) begin n_err++; $display("FAIL cont_if_rdata: got %h want %h", if_rdata, exp_v); end
    @(negedge clk); drive_idle();
  endtask

  task automatic test_hold();
    @(negedge clk); mem_req = 1'b1; mem_sel = 4'hF; mem_addr = 32'h400;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; stall = 6'b010000;
    mem_q.push_back(32'hCAFEF00D); #2;
    exp_v = mem_q.pop_front();
    n_cmp++; if (mem_rdata !== exp_v) begin n_err++; $display("FAIL hold_ack_rdata: got %h want %h", mem_rdata, exp_v); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus_ack = 1'b0; bus_rdata = 32'h0;
      if (i == 3) stall = 6'd0;
      mem_q.push_back(32'hCAFEF00D); #2;
      exp_v = mem_q.pop_front();
      n_cmp++; if (mem_rdata !== exp_v) begin n_err++; $display("FAIL hold_rdata_%0d: got %h want %h", i, mem_rdata, exp_v); end
      n_cmp++; if (mem_stallreq !== 1'b0) begin n_err++; $display("FAIL hold_stall_%0d: got %b want 0", i, mem_stallreq); end
    end
    @(negedge clk); mem_req = 1'b0; #2;
    n_cmp++; if (mem_rdata !== 32'd0) begin n_err++; $display("FAIL hold_release: got %h want 0", mem_rdata); end
    n_cmp++; if (bus_cyc !== 1'b0) begin n_err++; $display("FAIL hold_release_cyc: got %b want 0", bus_cyc); end
    drive_idle();
  endtask

  task automatic test_flush();
    @(negedge clk); mem_req = 1'b1; mem_sel = 4'hF; mem_addr = 32'h500;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h12345678; flush = 1'b1; stall = 6'b010000;
    mem_q.push_back(32'd0); #2;
    exp_v = mem_q.pop_front();
    n_cmp++; if (mem_rdata !== exp_v) begin n_err++; $display("FAIL flush_rdata: got %h want %h", mem_rdata, exp_v); end
    n_cmp++; if (mem_stallreq !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", mem_stallreq); end
    @(negedge clk); bus_ack = 1'b0; flush = 1'b0; mem_req = 1'b0; #2;
    n_cmp++; if (bus_cyc !== 1'b0) begin n_err++; $display("FAIL flush_cyc: got %b want 0", bus_cyc); end
    n_cmp++; if (mem_rdata !== 32'd0) begin n_err++; $display("FAIL flush_no_hold: got %h want 0", mem_rdata); end
    drive_idle();
  endtask

  task automatic test_timeout();
    int seen;
    seen = -1;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h600;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); #2;
      if (bus_timeout === 1'b1) begin seen = i; break; end
    end
    n_cmp++; if (seen != 1022) begin n_err++; $display("FAIL timeout_cycle: got %0d want 1022", seen); end
    n_cmp++; if (if_stallreq !== 1'b0) begin n_err++; $display("FAIL timeout_stall: got %b want 0", if_stallreq); end
    n_cmp++; if (if_rdata !== 32'd0) begin n_err++; $display("FAIL timeout_rdata: got %h want 0", if_rdata); end
    @(negedge clk); if_req = 1'b0; #2;
    n_cmp++; if (bus_cyc !== 1'b0) begin n_err++; $display("FAIL timeout_cyc: got %b want 0", bus_cyc); end
    n_cmp++; if (bus_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_pulse: got %b want 0", bus_timeout); end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h700;
    @(negedge clk); #2;
    n_cmp++; if (bus_cyc !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %b want 1", bus_cyc); end
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1; if_req = 1'b0; #2;
    n_cmp++; if (bus_cyc !== 1'b0) begin n_err++; $display("FAIL rstmid_cyc: got %b want 0", bus_cyc); end
    n_cmp++; if (bus_addr !== 32'd0) begin n_err++; $display("FAIL rstmid_addr: got %h want 0", bus_addr); end
    n_cmp++; if (if_rdata !== 32'd0) begin n_err++; $display("FAIL rstmid_rdata: got %h want 0", if_rdata); end
    @(negedge clk); if_req = 1'b1; if_addr = 32'h104;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h8C080000; if_q.push_back(32'h8C080000); #2;
    n_cmp++; if (bus_addr !== 32'h104) begin n_err++; $display("FAIL rstmid_fetch_addr: got %h want 104", bus_addr); end
    exp_v = if_q.pop_front();
    n_cmp++; if (if_rdata !== exp_v) begin n_err++; $display("FAIL rstmid_fetch_rdata: got %h want %h", if_rdata, exp_v); end
    @(negedge clk); drive_idle();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_hold();
    test_flush();
    test_timeout();
    test_reset_mid();
    n_cmp++; if (if_q.size() + mem_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", if_q.size() + mem_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Shares the single external memory bus (req/ack handshake) between the instruction-fetch port and the MEM-stage data port of the 6-stage pipeline.
- Produces stall requests toward the pipeline control block when a port is waiting on the bus.
- Holds returned data while the pipeline is stalled.
- Aborts the outstanding transaction on an exception flush.

Parameters:
- IF_STALL_BIT, 1: index of stall[] that freezes the instruction port's consumer (IF/ID).
- MEM_STALL_BIT, 4: index of stall[] that freezes the data port's consumer (MEM/WB).
- TIMEOUT, 1023: bus cycles without ack before abort. Counter is 10 bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- stall  in  6  pipeline stall vector from pipeline control
- flush  in  1  exception flush from pipeline control
- if_req  in  1  fetch request
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched instruction
- if_stallreq  out  1  fetch-port stall request
- mem_req  in  1  data request
- mem_we  in  1  data write enable
- mem_sel  in  4  byte selects
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data
- mem_stallreq  out  1  data-port stall request
- bus_cyc  out  1  bus request (cyc and stb combined)
- bus_we  out  1  bus write
- bus_sel  out  4  bus byte selects
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data
- bus_ack  in  1  bus acknowledge
- bus_timeout  out  1  one-cycle pulse on aborted transaction

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE; timeout counter cleared; held data registers cleared.
  - All registered bus outputs and bus_timeout go to 0.
  - Reset mid-transaction drops bus_cyc next cycle with no result returned.
- States: IDLE, I_BUSY, D_BUSY, I_HOLD, D_HOLD.
- IDLE:
  - flush=1 → stay IDLE.
  - Else mem_req=1 → D_BUSY. Data wins when both requests are present. The next cycle drives bus_cyc=1, bus_we/sel/addr/wdata from the mem_* inputs.
  - Else if_req=1 → I_BUSY with bus_we=0, bus_sel=4'hF, bus_addr=if_addr, bus_wdata=0.
- *_BUSY:
  - Bus outputs are held stable; the counter increments each cycle.
  - bus_ack=1 → bus_cyc=0 next cycle, capture bus_rdata into the port hold register, clear counter. Next state is *_HOLD if stall[port bit]=1, else IDLE.
- flush=1 in *_BUSY: return to IDLE, bus_cyc=0 next cycle, discard any same-cycle ack data. Flush takes priority over ack.
- Timeout in *_BUSY: counter==TIMEOUT-1 without ack → IDLE, bus_cyc=0, bus_timeout=1 for exactly one cycle, port data returned as 0 that cycle.
- *_HOLD: stay while stall[port bit]=1. When stall bit=0 or flush=1 → IDLE.
- Port data (combinational):
  - *_BUSY with ack: bus_rdata.
  - *_HOLD: hold register.
  - Timeout cycle: 0.
  - Otherwise: 0.
- mem_stallreq (combinational) = mem_req & ~flush & ~(D_BUSY & (bus_ack | timeout)) & ~D_HOLD.
- if_stallreq (combinational) = if_req & ~flush & ~(I_BUSY & (bus_ack | timeout)) & ~I_HOLD.
  - Consequence: if_stallreq stays 1 while the data port owns the bus.
- Stall-request latency: 0 cycles from request. Minimum transaction is 1 launch cycle plus 1 ack cycle, so ack in the first bus_cyc cycle completes in 2 cycles.
- Only one transaction is ever outstanding; no pipelining of bus requests.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, bus_ack on 2nd bus_cyc cycle with rdata=0x3C010001 → bus_addr=0x100, bus_sel=F, if_stallreq=1 until the ack cycle, then if_rdata=0x3C010001 with if_stallreq=0.
- Contention: if_req=1 and mem_req=1 (store 0xDEADBEEF to 0x200, sel=4'b0011) in the same IDLE cycle → data transaction first with bus_we=1, if_stallreq held 1; fetch issued after the data ack.
- Hold: load acked while stall[4]=1 for 3 cycles → D_HOLD, mem_rdata stays at the acked value through all 3 cycles; IDLE one cycle after stall[4] falls.
- Flush abort: flush=1 during D_BUSY, same cycle as ack → bus_cyc=0 next cycle, mem_rdata=0, state IDLE, no hold.
- Timeout: no ack for 1023 cycles → bus_cyc drops, bus_timeout one-cycle pulse, stallreq low that cycle.
- Reset mid I_BUSY → all outputs 0 next cycle, state IDLE, a later fetch works normally.
